alu_issue_stage: RTL and testbench

Upstream front end for the combinational alu block. Buffers requests (command, a, b) arriving on a valid/ready handshake in a small FIFO and issues them one at a time to the alu's enable/command/a/b inputs. Captures the alu's overflow/result in the same cycle and presents them on a registered response port with valid/ready, plus zero and illegal-command flags.

---
 rtl/alu_issue_stage.sv | 157 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the combinational alu: request FIFO, one-op-at-a-time issue, registered response.
// Optional macro ALU_ISSUE_STATS_EN adds saturating response/overflow counters (stat_ops, stat_ovf).
module alu_issue_stage #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_command,
  input  logic [SIZE-1:0]     req_a,
  input  logic [SIZE-1:0]     req_b,
  output logic                alu_enable,
  output logic [3:0]          alu_command,
  output logic [SIZE-1:0]     alu_a,
  output logic [SIZE-1:0]     alu_b,
  input  logic                alu_overflow,
  input  logic [2*SIZE-1:0]   alu_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*SIZE-1:0]   rsp_result,
  output logic                rsp_overflow,
  output logic                rsp_zero,
  output logic                rsp_illegal
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]         stat_ops,
  output logic [15:0]         stat_ovf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0]  FIRST_ILLEGAL = 4'd10;

  typedef struct packed {
    logic [3:0]      command;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
  } req_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_next;
  req_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic        push, pop, empty, capture, rsp_clear, illegal;

  assign req_ready = (count != FULL_CNT);
  assign empty     = (count == '0);
  assign push      = req_valid && req_ready;
  assign illegal   = (alu_command >= FIRST_ILLEGAL);
  assign alu_enable = (state == EXEC) && !illegal;

  // NOTE: storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{command: req_command, a: req_a, b: req_b};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    rsp_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        capture    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          // Drop valid on every handshake so an accepted response is never seen twice.
          rsp_clear = 1'b1;
          if (!empty) begin
            pop        = 1'b1;
            state_next = EXEC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      alu_command  <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_illegal  <= 1'b0;
    end else begin
      state <= state_next;
      if (pop) begin
        alu_command <= mem[rd_ptr].command;
        alu_a       <= mem[rd_ptr].a;
        alu_b       <= mem[rd_ptr].b;
      end
      if (capture) begin
        rsp_valid    <= 1'b1;
        rsp_illegal  <= illegal;
        rsp_result   <= illegal ? '0 : alu_result;
        rsp_overflow <= illegal ? 1'b0 : alu_overflow;
        rsp_zero     <= !illegal && (alu_result == '0);
      end else if (rsp_clear) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic rsp_fire;
  assign rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ops <= '0;
      stat_ovf <= '0;
    end else if (rsp_fire) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (rsp_overflow && stat_ovf != 16'hFFFF) stat_ovf <= stat_ovf + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural alu attached to the issue port.
module tb_alu_issue_stage;

  localparam int SIZE  = 8;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req_valid, req_ready;
  logic [3:0]        req_command;
  logic [SIZE-1:0]   req_a, req_b;
  logic              alu_enable;
  logic [3:0]        alu_command;
  logic [SIZE-1:0]   alu_a, alu_b;
  logic              alu_overflow;
  logic [2*SIZE-1:0] alu_result;
  logic              rsp_valid, rsp_ready;
  logic [2*SIZE-1:0] rsp_result;
  logic              rsp_overflow, rsp_zero, rsp_illegal;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0]       stat_ops, stat_ovf;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_command(req_command), .req_a(req_a), .req_b(req_b),
    .alu_enable(alu_enable), .alu_command(alu_command), .alu_a(alu_a), .alu_b(alu_b),
    .alu_overflow(alu_overflow), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
`ifdef ALU_ISSUE_STATS_EN
    , .stat_ops(stat_ops), .stat_ovf(stat_ovf)
`endif
  );

  // Behavioural alu: 0 AND, 1 OR, 4 SIZE-bit add with carry as overflow, 8 multiply.
  // Illegal codes drive junk regardless of enable, so the stage must mask them itself.
  logic [SIZE:0] sum;
  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    sum          = {1'b0, alu_a} + {1'b0, alu_b};
    if (alu_command >= 4'd10) begin
      alu_result   = 16'hBEEF;
      alu_overflow = 1'b1;
    end else if (alu_enable) begin
      case (alu_command)
        4'd0:    alu_result = {8'h00, alu_a & alu_b};
        4'd1:    alu_result = {8'h00, alu_a | alu_b};
        4'd4:    begin alu_result = {8'h00, sum[SIZE-1:0]}; alu_overflow = sum[SIZE]; end
        4'd8:    alu_result = alu_a * alu_b;
        default: alu_result = {alu_a, alu_b};
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
    req_valid   = 1'b1;
    req_command = cmd;
    req_a       = a;
    req_b       = b;
  endtask

  // Single request from idle with rsp_ready high: pop at E1, capture at E2, accepted at E3.
  task automatic run_single(input string tag, input logic [3:0] cmd, input logic [7:0] a,
                            input logic [7:0] b, input logic [15:0] exp_res, input logic exp_ovf,
                            input logic exp_zero, input logic exp_ill, input logic exp_en);
    drive_req(cmd, a, b);
    tick();  // E0
    req_valid = 1'b0;
    check({tag, " en@E0"}, alu_enable, 1'b0);
    check({tag, " valid@E0"}, rsp_valid, 1'b0);
    tick();  // E1
    check({tag, " en@E1"}, alu_enable, exp_en);
    check({tag, " valid@E1"}, rsp_valid, 1'b0);
    tick();  // E2
    check({tag, " en@E2"}, alu_enable, 1'b0);
    check({tag, " valid@E2"}, rsp_valid, 1'b1);
    check({tag, " result"}, rsp_result, exp_res);
    check({tag, " ovf"}, rsp_overflow, exp_ovf);
    check({tag, " zero"}, rsp_zero, exp_zero);
    check({tag, " illegal"}, rsp_illegal, exp_ill);
    tick();  // E3
    check({tag, " valid@E3"}, rsp_valid, 1'b0);
  endtask

  initial begin
    int k;
    logic seen;
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_command = '0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready   = 1'b1;
    #23 reset_n = 1'b1;
    tick();
    check("rst req_ready", req_ready, 1'b1);
    check("rst rsp_valid", rsp_valid, 1'b0);
    check("rst alu_enable", alu_enable, 1'b0);
    check("rst rsp_result", rsp_result, 16'h0000);

    run_single("and", 4'd0, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b1);
    run_single("add_ovf", 4'd4, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
    run_single("illegal", 4'd12, 8'h55, 8'hAA, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back: second response exactly two cycles after the first.
    drive_req(4'd8, 8'h10, 8'h10);
    tick();  // E0
    drive_req(4'd1, 8'h0F, 8'hF0);
    tick();  // E1
    req_valid = 1'b0;
    tick();  // E2
    check("b2b first valid", rsp_valid, 1'b1);
    check("b2b first result", rsp_result, 16'h0100);
    tick();  // E3
    check("b2b gap valid", rsp_valid, 1'b0);
    tick();  // E4
    check("b2b second valid", rsp_valid, 1'b1);
    check("b2b second result", rsp_result, 16'h00FF);
    tick();

    // Capacity: DEPTH in FIFO plus one in flight, with the consumer stalled.
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_req(4'd1, 8'(1 << i), 8'h00);
      check($sformatf("cap req_ready[%0d]", i), req_ready, (i < 5) ? 1'b1 : 1'b0);
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall valid[%0d]", i), rsp_valid, 1'b1);
      check($sformatf("stall result[%0d]", i), rsp_result, 16'h0001);
    end
    check("full req_ready", req_ready, 1'b0);
    rsp_ready = 1'b1;
    tick();
    check("req_ready after pop", req_ready, 1'b1);
    k = 1;
    for (int cyc = 0; cyc < 40 && k < 5; cyc++) begin
      tick();
      if (rsp_valid) begin
        check($sformatf("drain result[%0d]", k), rsp_result, 16'(1 << k));
        k++;
      end
    end
    check("drain count", k, 5);
    tick();

    // Reset while in EXEC with three requests buffered.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(4'd0, 8'hFF, 8'(i + 1));
      tick();
    end
    rsp_ready = 1'b1;
    drive_req(4'd0, 8'hFF, 8'h05);
    tick();
    req_valid = 1'b0;
    check("pre-rst alu_enable", alu_enable, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("in-rst alu_enable", alu_enable, 1'b0);
    check("in-rst rsp_valid", rsp_valid, 1'b0);
    tick();
    #3 reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | rsp_valid | alu_enable;
    end
    check("post-rst no activity", seen, 1'b0);
    check("post-rst req_ready", req_ready, 1'b1);
`ifdef ALU_ISSUE_STATS_EN
    check("post-rst stat_ops", stat_ops, 16'h0000);
    check("post-rst stat_ovf", stat_ovf, 16'h0000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
